// File: rtl/team_06_spi_pkg.sv
// team_06_spi_pkg
// Shared types and constants for the team_06 SPI shift-out stage.
//   spi_state_t        : FSM state encoding (IDLE, SETUP, SHIFT, HOLD)
//   SPI_DEFAULT_WIDTH  : default transfer width in bits
package team_06_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int SPI_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/team_06_edge_detect.sv
// team_06_edge_detect
// Purely combinational edge decode of the clock divider output, using the
// divider's own one-cycle-delayed copy so no extra flop is needed here.
// Ports:
//   div_clk      in  divided clock (data signal, never used as a clock)
//   div_clk_past in  div_clk delayed by one system clock
//   tick         out either edge of div_clk (one half-period strobe)
//   rise         out rising edge of div_clk
//   fall         out falling edge of div_clk
module team_06_edge_detect (
  input  logic div_clk,
  input  logic div_clk_past,
  output logic tick,
  output logic rise,
  output logic fall
);

  assign tick = div_clk ^ div_clk_past;
  assign rise = div_clk & ~div_clk_past;
  assign fall = ~div_clk & div_clk_past;

endmodule

// File: rtl/team_06_spi_shifter.sv
// team_06_spi_shifter
// SPI mode-0 serialiser fed by the team clock divider. Each edge of div_clk
// is one half-bit strobe; everything runs on clk.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   div_clk(_past)    divider output and its one-cycle-delayed copy
//   tx_data/valid     word to send (MSB first) with valid
//   tx_ready          word accepted this cycle (IDLE only, registered)
//   sclk, mosi, cs_n  SPI link (sclk idles low)
//   done              one-cycle pulse at end of transfer
//   busy              high whenever the FSM is not IDLE
// Optional macro TEAM06_SPI_MISO_EN adds miso in, rx_data/rx_valid out.
module team_06_spi_shifter
  import team_06_spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_clk,
  input  logic                  div_clk_past,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  done,
  output logic                  busy
`ifdef TEAM06_SPI_MISO_EN
  ,
  input  logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  spi_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  done_q, done_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  busy_q, busy_d;
`ifdef TEAM06_SPI_MISO_EN
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
`endif

  logic tick, edge_rise, edge_fall;
  // rise/fall serve other divider consumers; this block needs only the strobe.
  logic edges_unused;

  team_06_edge_detect u_edge (
    .div_clk      (div_clk),
    .div_clk_past (div_clk_past),
    .tick         (tick),
    .rise         (edge_rise),
    .fall         (edge_fall)
  );

  assign edges_unused = edge_rise ^ edge_fall;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    done_d    = 1'b0;
`ifdef TEAM06_SPI_MISO_EN
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d   = tx_data;
          bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
          cs_n_d    = 1'b0;
          mosi_d    = tx_data[DATA_WIDTH-1];
          state_d   = SETUP;
`ifdef TEAM06_SPI_MISO_EN
          rx_shift_d = '0;
`endif
        end
      end
      SETUP: begin
        // one half-bit of cs_n-to-sclk setup before the first rising edge
        if (tick) begin
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
`ifdef TEAM06_SPI_MISO_EN
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
`endif
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == '0) begin
              state_d = HOLD;
            end else begin
              // next bit is launched on the same cycle sclk falls
              shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q - CNT_W'(1);
              mosi_d    = shift_q[DATA_WIDTH-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef TEAM06_SPI_MISO_EN
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // registered from next state so tx_valid never reaches tx_ready combinationally
    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef TEAM06_SPI_MISO_EN
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
`ifdef TEAM06_SPI_MISO_EN
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`endif
    end
  end

  assign tx_ready = tx_ready_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign done     = done_q;
  assign busy     = busy_q;
`ifdef TEAM06_SPI_MISO_EN
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`endif

endmodule

// File: tb/tb_team_06_spi_shifter.sv
// Testbench for team_06_spi_shifter: table-driven transfers, random transfers,
// and hand-written reset / busy / back-to-back sequences. A negedge monitor
// reconstructs each transfer from the SPI pins; the main process compares it
// with the word that was sent and the spec's tick/pulse counts.
module tb_team_06_spi_shifter;
  localparam int W      = 8;
  localparam int XTICKS = 2 + 2 * W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_clk = 1'b0;
  logic         div_clk_past = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, sclk, mosi, cs_n, done, busy;
`ifdef TEAM06_SPI_MISO_EN
  logic         miso;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  assign miso = mosi;
`endif

  team_06_spi_shifter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .div_clk_past(div_clk_past),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .done(done), .busy(busy)
`ifdef TEAM06_SPI_MISO_EN
    , .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid)
`endif
  );

  always #5 clk = ~clk;

  // divider model: div_clk toggles every tick_per cycles (0 = stopped)
  int tick_per = 0;
  int div_cnt  = 0;
  always @(posedge clk) begin
    div_clk_past <= div_clk;
    if (tick_per != 0) begin
      if (div_cnt >= tick_per - 1) begin
        div_clk <= ~div_clk;
        div_cnt <= 0;
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [W-1:0] word;
    int           ticks;
    int           cycles;
    int           pulses;
    int           cs_gap;
    bit           cs_ok;
    bit           hs_ok;
    bit           end_ok;
    logic [W-1:0] rxd;
    bit           rxv;
  } xfer_t;

  xfer_t mon [32];
  int    mon_n     = 0;
  int    done_seen = 0;

  // monitor: observes pins only, builds one record per completed transfer
  initial begin : monitor
    bit    in_x = 0;
    xfer_t cur;
    logic  sclk_prev = 1'b0;
    int    cs_hi_run = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      cs_hi_run = (cs_n === 1'b1) ? cs_hi_run + 1 : 0;
      if (rst) begin
        in_x = 0;
      end else begin
        if (in_x && done === 1'b1) begin
          cur.end_ok = (cs_n === 1'b1) && (mosi === 1'b0) && (tx_ready === 1'b1) && (busy === 1'b0);
`ifdef TEAM06_SPI_MISO_EN
          cur.rxd = rx_data;
          cur.rxv = rx_valid;
`endif
          if (mon_n < 32) mon[mon_n] = cur;
          mon_n++;
          in_x = 0;
        end else if (in_x) begin
          if (div_clk ^ div_clk_past) cur.ticks++;
          cur.cycles++;
          if (cs_n !== 1'b0) cur.cs_ok = 0;
          if (tx_ready !== 1'b0 || busy !== 1'b1) cur.hs_ok = 0;
          if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            cur.word = {cur.word[W-2:0], mosi};
            cur.pulses++;
          end
        end
        if (!in_x && tx_valid === 1'b1 && tx_ready === 1'b1) begin
          in_x       = 1;
          cur        = '{default: 0};
          cur.cs_ok  = 1;
          cur.hs_ok  = 1;
          cur.cs_gap = cs_hi_run;
        end
      end
      sclk_prev = sclk;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    bit ok = 0;
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("accept_timeout", int'(ok), 1);
  endtask

  task automatic wait_xfer(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mon_n >= target) begin ok = 1; break; end
    end
    chk("done_timeout", int'(ok), 1);
  endtask

  task automatic check_rec(input int idx, input logic [W-1:0] d, input int per);
    chk("mosi_word", int'(mon[idx].word), int'(d));
    chk("tick_count", mon[idx].ticks, XTICKS);
    chk("sclk_pulses", mon[idx].pulses, W);
    chk("cs_low_during", int'(mon[idx].cs_ok), 1);
    chk("busy_not_ready", int'(mon[idx].hs_ok), 1);
    chk("idle_after_done", int'(mon[idx].end_ok), 1);
    if (per == 1) chk("fast_cycles", mon[idx].cycles, XTICKS);
`ifdef TEAM06_SPI_MISO_EN
    chk("rx_data", int'(mon[idx].rxd), int'(d));
    chk("rx_valid_with_done", int'(mon[idx].rxv), 1);
`endif
  endtask

  typedef struct {
    logic [W-1:0] data;
    int           per;
  } vec_t;

  initial begin : main
    vec_t vt [6];
    bit   ok;
    int   n0, d0;
    vt[0] = '{8'hA5, 4};
    vt[1] = '{8'h55, 1};
    vt[2] = '{8'h00, 2};
    vt[3] = '{8'hFF, 3};
    vt[4] = '{8'hC3, 2};
    vt[5] = '{8'h81, 5};

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);

    // no ticks in IDLE: must stay idle
    tick_per = 2;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_no_start", int'(cs_n), 1);

    // table-driven transfers
    for (int i = 0; i < 6; i++) begin
      tick_per = vt[i].per;
      repeat (4) @(posedge clk);
      n0 = mon_n;
      send(vt[i].data);
      wait_xfer(n0 + 1, ok);
      if (ok) check_rec(n0, vt[i].data, vt[i].per);
    end

    // busy rejection: 0x3C offered mid-transfer must be dropped
    tick_per = 4;
    n0 = mon_n;
    d0 = done_seen;
    send(8'h81);
    repeat (20) @(posedge clk);
    #1 tx_data = 8'h3C; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_xfer(n0 + 1, ok);
    if (ok) check_rec(n0, 8'h81, 4);
    repeat (200) @(posedge clk);
    chk("busy_reject_count", mon_n - n0, 1);
    chk("busy_reject_dones", done_seen - d0, 1);

    // back-to-back with tx_valid held high
    tick_per = 2;
    n0 = mon_n;
    d0 = done_seen;
    @(posedge clk); #1 tx_data = 8'h0F; tx_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1 tx_data = 8'hF0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin ok = ok && 1; break; end
      if (i == 999) ok = 0;
    end
    @(posedge clk); #1 tx_valid = 1'b0;
    chk("b2b_accept", int'(ok), 1);
    wait_xfer(n0 + 2, ok);
    if (ok) begin
      check_rec(n0, 8'h0F, 2);
      check_rec(n0 + 1, 8'hF0, 2);
      chk("b2b_cs_gap", int'(mon[n0 + 1].cs_gap >= 1), 1);
      chk("b2b_dones", done_seen - d0, 2);
    end

    // reset mid-shift of 0xFF
    tick_per = 4;
    n0 = mon_n;
    send(8'hFF);
    repeat (40) @(posedge clk);
    d0 = done_seen;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs_n", int'(cs_n), 1);
    chk("mid_rst_sclk", int'(sclk), 0);
    chk("mid_rst_mosi", int'(mosi), 0);
    chk("mid_rst_tx_ready", int'(tx_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (200) @(posedge clk);
    chk("mid_rst_no_done", done_seen - d0, 0);
    chk("mid_rst_no_xfer", mon_n - n0, 0);

    // random transfers at random tick rates
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] d;
      int per;
      d   = W'($urandom);
      per = int'($urandom_range(1, 4));
      tick_per = per;
      repeat (3) @(posedge clk);
      n0 = mon_n;
      send(d);
      wait_xfer(n0 + 1, ok);
      if (ok) check_rec(n0, d, per);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
